meta_write_arbiter: RTL
=======================

Name: meta_write_arbiter

Overview:
- Parametrised N-way arbiter for cache metadata write requests (set index, way enable, tag, coherence state) feeding the metadata array write port.
- Generalises the fixed 3-input, fixed-priority combinational metadata arbiter:
  - channel count and field widths are parameters;
  - arbitration mode is selectable (fixed priority or round-robin);
  - the winner is captured in a registered output stage, so the array sees stable, timing-clean inputs.

Parameters:
- N, 3, number of requesting channels (1..16).
- CHOSEN_W, 2, width of io_chosen; must be at least ceil(log2(N)), minimum 1.
- IDX_W, 7, set-index width.
- WAYS, 1, way-enable width (one-hot way mask).
- TAG_W, 19, tag width.
- COH_W, 2, coherence-state width.
- RR_MODE, 0, 0 = fixed priority (channel 0 highest); 1 = round-robin.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_in_valid  in  N  per-channel request valid.
- io_in_ready  out  N  per-channel accept.
- io_in_bits_idx  in  N*IDX_W  channel i occupies bits [i*IDX_W +: IDX_W].
- io_in_bits_way_en  in  N*WAYS  packed per channel, same scheme.
- io_in_bits_data_tag  in  N*TAG_W  packed per channel.
- io_in_bits_data_coh_state  in  N*COH_W  packed per channel.
- io_out_ready  in  1  downstream accept.
- io_out_valid  out  1  registered request valid.
- io_out_bits_idx  out  IDX_W  registered index.
- io_out_bits_way_en  out  WAYS  registered way mask.
- io_out_bits_data_tag  out  TAG_W  registered tag.
- io_out_bits_data_coh_state  out  COH_W  registered coherence state.
- io_chosen  out  CHOSEN_W  index of the channel whose request is held in the output register.

Behaviour:
- Reset (reset low, asynchronous):
  - io_out_valid = 0;
  - all io_out_bits_* = 0 and io_chosen = 0;
  - round-robin pointer last_grant = N-1, so channel 0 has first priority.
  - Asserting reset mid-transfer discards the held request; it is not replayed.
- Load condition: load = ~io_out_valid | io_out_ready (output slot empty or being drained this cycle).
- Grant (combinational, one-hot, from io_in_valid only):
  - RR_MODE=0: lowest-indexed valid channel.
  - RR_MODE=1: first valid channel in search order last_grant+1, last_grant+2, …, wrapping modulo N; last_grant itself is searched last.
- io_in_ready[i] = load & grant[i].
  - At most one ready bit is high per cycle.
  - Ready may depend combinationally on io_in_valid and io_out_ready.
- Rising edge with load=1 and any valid:
  - output register captures the winner's fields and its index into io_chosen;
  - io_out_valid = 1;
  - RR_MODE=1: last_grant <= winner.
- Rising edge with load=1 and no valid: io_out_valid = 0; bits and io_chosen hold their previous values.
- Rising edge with load=0 (valid held, downstream stalled): output register and last_grant unchanged; all io_in_ready are 0.
- Stall stability: while io_out_valid=1 and io_out_ready=0, all outputs are stable.
- Timing:
  - latency is 1 cycle, input handshake to io_out_valid;
  - throughput is 1 request per cycle when io_out_ready is held high (back-to-back refill on the same edge the held entry drains).
- The pointer moves only on an accepted grant, never on idle cycles.
- N=1: grant = io_in_valid[0]; io_chosen is always 0; the block degenerates to a single pipeline register.
- Fairness (RR_MODE=1): with all N channels continuously valid, each channel is granted exactly once every N accepted transfers.
- No data-dependent arithmetic. The only arithmetic is pointer increment modulo N (N need not be a power of two).

Test Plan:
- Reset/idle: hold reset low, then release with all valid=0 -> io_out_valid=0, io_chosen=0, all io_in_ready=0 after the first edge with load=1.
- Fixed priority (N=3, RR_MODE=0): valid=3'b110, ch1 idx=0x12, ch2 idx=0x34, io_out_ready=1 -> io_in_ready=3'b010; next cycle io_out_valid=1, io_out_bits_idx=0x12, io_chosen=1.
- Round-robin (N=3, RR_MODE=1): all valid for 6 cycles, io_out_ready=1 -> io_chosen sequence 0,1,2,0,1,2.
- Round-robin wrap/skip (N=5): last_grant=3, valid=5'b00101 -> ch0 granted (wrap past ch4), io_chosen=0.
- Backpressure: io_out_valid=1 with tag=0x7FFFF, io_out_ready=0 for 4 cycles while ch2 valid -> outputs stable, io_in_ready=0. Then io_out_ready=1 -> ch2 accepted that cycle, presented next cycle.
- Reset mid-operation: assert reset while io_out_valid=1 and io_out_ready=0 -> io_out_valid=0 immediately (asynchronous). After release, RR order restarts at ch0.

Source files
------------

// File: rtl/meta_write_arbiter_if.sv
// Metadata write request bundle: N requesting channels in, one registered
// winner out, plus the index of the channel that produced the held request.
interface meta_write_arbiter_if #(
    parameter int N        = 3,
    parameter int CHOSEN_W = 2,
    parameter int IDX_W    = 7,
    parameter int WAYS     = 1,
    parameter int TAG_W    = 19,
    parameter int COH_W    = 2
);
    logic [N-1:0]       io_in_valid;
    logic [N-1:0]       io_in_ready;
    logic [N*IDX_W-1:0] io_in_bits_idx;
    logic [N*WAYS-1:0]  io_in_bits_way_en;
    logic [N*TAG_W-1:0] io_in_bits_data_tag;
    logic [N*COH_W-1:0] io_in_bits_data_coh_state;

    logic               io_out_ready;
    logic               io_out_valid;
    logic [IDX_W-1:0]   io_out_bits_idx;
    logic [WAYS-1:0]    io_out_bits_way_en;
    logic [TAG_W-1:0]   io_out_bits_data_tag;
    logic [COH_W-1:0]   io_out_bits_data_coh_state;
    logic [CHOSEN_W-1:0] io_chosen;

    // Requesters and the array-side consumer.
    modport master (
        output io_in_valid, io_in_bits_idx, io_in_bits_way_en,
               io_in_bits_data_tag, io_in_bits_data_coh_state, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits_idx, io_out_bits_way_en,
               io_out_bits_data_tag, io_out_bits_data_coh_state, io_chosen
    );

    // The arbiter itself.
    modport slave (
        input  io_in_valid, io_in_bits_idx, io_in_bits_way_en,
               io_in_bits_data_tag, io_in_bits_data_coh_state, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits_idx, io_out_bits_way_en,
               io_out_bits_data_tag, io_out_bits_data_coh_state, io_chosen
    );
endinterface

// File: rtl/meta_write_arbiter.sv
// N-way metadata write arbiter with a registered output stage.
// Fixed priority (channel 0 highest) or round-robin, selected by RR_MODE.
// The output register refills on the same edge it drains, giving one
// request per cycle when the array keeps io_out_ready high.
module meta_write_arbiter #(
    parameter int N        = 3,
    parameter int CHOSEN_W = 2,
    parameter int IDX_W    = 7,
    parameter int WAYS     = 1,
    parameter int TAG_W    = 19,
    parameter int COH_W    = 2,
    parameter int RR_MODE  = 0
) (
    input logic clk,
    input logic reset,
    meta_write_arbiter_if.slave io
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(N - 1);

    logic              load;
    logic              found;
    logic [N-1:0]      grant;
    logic [PTR_W-1:0]  last_grant;
    logic [PTR_W-1:0]  first_cand;
    logic [PTR_W-1:0]  cand;
    logic [PTR_W-1:0]  winner;

    logic [IDX_W-1:0]  sel_idx;
    logic [WAYS-1:0]   sel_way_en;
    logic [TAG_W-1:0]  sel_tag;
    logic [COH_W-1:0]  sel_coh;

    logic                out_valid;
    logic [IDX_W-1:0]    out_idx;
    logic [WAYS-1:0]     out_way_en;
    logic [TAG_W-1:0]    out_tag;
    logic [COH_W-1:0]    out_coh;
    logic [CHOSEN_W-1:0] out_chosen;

    // The slot can take a new request when empty or when it drains this cycle.
    assign load = ~out_valid | io.io_out_ready;

    // Walk the channels once, starting after the last winner in round-robin
    // mode (or at channel 0 in fixed mode); the first valid one wins.
    always_comb begin
        first_cand = '0;
        if (RR_MODE != 0) begin
            first_cand = (last_grant == LAST_CH) ? '0 : last_grant + PTR_W'(1);
        end
        cand   = first_cand;
        winner = '0;
        found  = 1'b0;
        grant  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && io.io_in_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
            cand = (cand == LAST_CH) ? '0 : cand + PTR_W'(1);
        end
        if (found) begin
            grant[winner] = 1'b1;
        end
    end

    // Route the winning channel's fields toward the output register.
    always_comb begin
        sel_idx    = io.io_in_bits_idx[int'(winner)*IDX_W +: IDX_W];
        sel_way_en = io.io_in_bits_way_en[int'(winner)*WAYS +: WAYS];
        sel_tag    = io.io_in_bits_data_tag[int'(winner)*TAG_W +: TAG_W];
        sel_coh    = io.io_in_bits_data_coh_state[int'(winner)*COH_W +: COH_W];
    end

    assign io.io_in_ready = {N{load}} & grant;

    // Output register: capture the winner on load, go idle when nothing asks,
    // and hold everything while the array stalls us. Bits keep their old
    // value across idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_way_en <= '0;
            out_tag    <= '0;
            out_coh    <= '0;
            out_chosen <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_idx    <= sel_idx;
                out_way_en <= sel_way_en;
                out_tag    <= sel_tag;
                out_coh    <= sel_coh;
                out_chosen <= CHOSEN_W'(winner);
            end
        end
    end

    // Round-robin pointer only advances on an accepted grant; resetting it to
    // the last channel makes channel 0 the first to be searched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= LAST_CH;
        end else if ((RR_MODE != 0) && load && found) begin
            last_grant <= winner;
        end
    end

    assign io.io_out_valid               = out_valid;
    assign io.io_out_bits_idx            = out_idx;
    assign io.io_out_bits_way_en         = out_way_en;
    assign io.io_out_bits_data_tag       = out_tag;
    assign io.io_out_bits_data_coh_state = out_coh;
    assign io.io_chosen                  = out_chosen;
endmodule
